axi4_default_slave: RTL

//   Error-responding AXI4 slave downstream of axi4_address_decoder. The interconnect routes here every
//   AW/AR the decoder leaves unselected (no slave_select bit) or flags with access_error. Completes each

---
 rtl/axi4_default_slave.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/axi4_default_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi4_default_slave
// Purpose  : Completes every unrouted or denied AXI4 transaction with an error
//            response, and logs an error count plus the last faulting address.
// Revision : 1.0
// ============================================================================
module axi4_default_slave #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = 4,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [ID_WIDTH-1:0]      s_awid,
    input  logic [ADDR_WIDTH-1:0]    s_awaddr,
    input  logic                     s_aw_perm_err,
    input  logic                     s_awvalid,
    output logic                     s_awready,
    input  logic                     s_wlast,
    input  logic                     s_wvalid,
    output logic                     s_wready,
    output logic [ID_WIDTH-1:0]      s_bid,
    output logic [1:0]               s_bresp,
    output logic                     s_bvalid,
    input  logic                     s_bready,
    input  logic [ID_WIDTH-1:0]      s_arid,
    input  logic [ADDR_WIDTH-1:0]    s_araddr,
    input  logic [7:0]               s_arlen,
    input  logic                     s_ar_perm_err,
    input  logic                     s_arvalid,
    output logic                     s_arready,
    output logic [ID_WIDTH-1:0]      s_rid,
    output logic [DATA_WIDTH-1:0]    s_rdata,
    output logic [1:0]               s_rresp,
    output logic                     s_rlast,
    output logic                     s_rvalid,
    input  logic                     s_rready,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [ADDR_WIDTH-1:0]    last_err_addr,
    output logic                     last_err_is_write
);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [ERR_CNT_WIDTH-1:0] ERR_CNT_MAX = '1;

    logic [1:0]               w_state_q, w_state_d;
    logic [0:0]               r_state_q, r_state_d;
    logic                     en_q;
    logic [ID_WIDTH-1:0]      bid_q, bid_d;
    logic [1:0]               bresp_q, bresp_d;
    logic [ID_WIDTH-1:0]      rid_q, rid_d;
    logic [1:0]               rresp_q, rresp_d;
    logic [7:0]               len_q, len_d;
    logic [7:0]               beat_cnt_q, beat_cnt_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0]    last_addr_q, last_addr_d;
    logic                     last_is_wr_q, last_is_wr_d;

    logic                     aw_hs, w_hs, ar_hs, r_hs;
    logic [1:0]               err_inc;
    logic [ERR_CNT_WIDTH:0]   err_sum;

    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid  & s_wready;
    assign ar_hs = s_arvalid & s_arready;
    assign r_hs  = s_rvalid  & s_rready;

    // en_q holds the address readies low for the whole reset cycle
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state_q    <= W_IDLE;
            r_state_q    <= R_IDLE;
            en_q         <= 1'b0;
            bid_q        <= '0;
            bresp_q      <= '0;
            rid_q        <= '0;
            rresp_q      <= '0;
            len_q        <= '0;
            beat_cnt_q   <= '0;
            err_cnt_q    <= '0;
            last_addr_q  <= '0;
            last_is_wr_q <= 1'b0;
        end else begin
            w_state_q    <= w_state_d;
            r_state_q    <= r_state_d;
            en_q         <= 1'b1;
            bid_q        <= bid_d;
            bresp_q      <= bresp_d;
            rid_q        <= rid_d;
            rresp_q      <= rresp_d;
            len_q        <= len_d;
            beat_cnt_q   <= beat_cnt_d;
            err_cnt_q    <= err_cnt_d;
            last_addr_q  <= last_addr_d;
            last_is_wr_q <= last_is_wr_d;
        end
    end

    always_comb begin
        w_state_d    = w_state_q;
        bid_d        = bid_q;
        bresp_d      = bresp_q;
        r_state_d    = r_state_q;
        rid_d        = rid_q;
        rresp_d      = rresp_q;
        len_d        = len_q;
        beat_cnt_d   = beat_cnt_q;
        last_addr_d  = last_addr_q;
        last_is_wr_d = last_is_wr_q;

        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    w_state_d = W_DATA;
                    bid_d     = s_awid;
                    bresp_d   = s_aw_perm_err ? RESP_SLVERR : RESP_DECERR;
                end
            end
            W_DATA: begin
                // Burst end is taken from wlast alone; the write length is never tracked
                if (w_hs && s_wlast) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_bvalid && s_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d  = R_DATA;
                    rid_d      = s_arid;
                    len_d      = s_arlen;
                    rresp_d    = s_ar_perm_err ? RESP_SLVERR : RESP_DECERR;
                    beat_cnt_d = '0;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    if (s_rlast) begin
                        r_state_d = R_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        err_inc = {1'b0, aw_hs} + {1'b0, ar_hs};
        err_sum = {1'b0, err_cnt_q} + {{(ERR_CNT_WIDTH-1){1'b0}}, err_inc};
        err_cnt_d = err_sum[ERR_CNT_WIDTH] ? ERR_CNT_MAX : err_sum[ERR_CNT_WIDTH-1:0];

        // A simultaneous write fault takes precedence in the address log
        if (aw_hs) begin
            last_addr_d  = s_awaddr;
            last_is_wr_d = 1'b1;
        end else if (ar_hs) begin
            last_addr_d  = s_araddr;
            last_is_wr_d = 1'b0;
        end
    end

    always_comb begin
        s_awready         = en_q && (w_state_q == W_IDLE);
        s_wready          = (w_state_q == W_DATA);
        s_bvalid          = (w_state_q == W_RESP);
        s_bid             = bid_q;
        s_bresp           = bresp_q;
        s_arready         = en_q && (r_state_q == R_IDLE);
        s_rvalid          = (r_state_q == R_DATA);
        s_rlast           = (r_state_q == R_DATA) && (beat_cnt_q == len_q);
        s_rid             = rid_q;
        s_rresp           = rresp_q;
        s_rdata           = '0;
        err_count         = err_cnt_q;
        last_err_addr     = last_addr_q;
        last_err_is_write = last_is_wr_q;
    end

endmodule
`default_nettype wire
